// File: rtl/detector_jogada.sv
// Play detector: synchronizes and debounces the switch inputs, accepts a
// stable one-hot value as a play and rejects stable multi-bit values.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   OCIOSO   | idle, waiting for a nonzero switch value while enabled
//   FILTRA   | debouncing the captured value for DEBOUNCE cycles
//   EMITE    | one-cycle jogada pulse, chaves_reg loaded on entry
//   ESPERA   | waiting for all switches to be released
//   INVALIDA | one-cycle multipla pulse for a multi-bit value
module detector_jogada #(
  parameter int DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] chaves,
  output logic       jogada,
  output logic       multipla,
  output logic [3:0] chaves_reg,
  output logic [3:0] db_estado
);

  localparam logic [3:0] OCIOSO   = 4'h0;
  localparam logic [3:0] FILTRA   = 4'h1;
  localparam logic [3:0] EMITE    = 4'h2;
  localparam logic [3:0] ESPERA   = 4'h3;
  localparam logic [3:0] INVALIDA = 4'hE;

  // Debounce terminal count; the counter exits FILTRA here so it never wraps.
  localparam logic [7:0] CNT_TC = 8'(DEBOUNCE - 1);

  logic [3:0] s1;
  logic [3:0] s2;
  logic [3:0] cap;
  logic [3:0] estado;
  logic [7:0] cnt;
  logic       cap_onehot;

  assign cap_onehot = (cap != 4'b0000) && ((cap & (cap - 4'd1)) == 4'b0000);

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 4'b0000;
      s2 <= 4'b0000;
    end else begin
      s1 <= chaves;
      s2 <= s1;
    end
  end

  // Detection FSM with capture register, debounce counter and play register.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= OCIOSO;
      cap        <= 4'b0000;
      cnt        <= 8'd0;
      chaves_reg <= 4'b0000;
    end else begin
      case (estado)
        OCIOSO: begin
          if (habilita && (s2 != 4'b0000)) begin
            estado <= FILTRA;
            cap    <= s2;
            cnt    <= 8'd0;
          end
        end
        FILTRA: begin
          if ((s2 != cap) || !habilita) begin
            estado <= OCIOSO;
            cnt    <= 8'd0;
          end else if (cnt == CNT_TC) begin
            if (cap_onehot) begin
              estado     <= EMITE;
              chaves_reg <= cap;
            end else begin
              estado <= INVALIDA;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        EMITE:    estado <= ESPERA;
        INVALIDA: estado <= ESPERA;
        ESPERA: begin
          if (s2 == 4'b0000) estado <= OCIOSO;
        end
        default:  estado <= OCIOSO;
      endcase
    end
  end

  assign jogada    = (estado == EMITE);
  assign multipla  = (estado == INVALIDA);
  assign db_estado = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Self-checking bench for detector_jogada with DEBOUNCE=4.
module tb_detector_jogada;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita;
  logic [3:0] chaves;
  logic       jogada;
  logic       multipla;
  logic [3:0] chaves_reg;
  logic [3:0] db_estado;

  int n_pass  = 0;
  int n_total = 0;

  int   jog_total = 0;
  int   mul_total = 0;
  int   width_err = 0;
  logic prev_jog  = 1'b0;
  logic prev_mul  = 1'b0;

  typedef struct {
    logic       hab;
    logic [3:0] ch;
    int         hold;
    int         n_jog;
    int         n_mul;
    logic [3:0] reg_exp;
  } vec_t;

  typedef struct {
    string      name;
    int         n_jog;
    int         n_mul;
    logic [3:0] reg_exp;
    int         jog0;
    int         mul0;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];

  always #5 clock = ~clock;

  detector_jogada #(.DEBOUNCE(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .habilita   (habilita),
    .chaves     (chaves),
    .jogada     (jogada),
    .multipla   (multipla),
    .chaves_reg (chaves_reg),
    .db_estado  (db_estado)
  );

  // Pulse monitor: counts pulses and flags any pulse longer than one cycle.
  always @(negedge clock) begin
    if (jogada) jog_total++;
    if (multipla) mul_total++;
    if ((jogada && prev_jog) || (multipla && prev_mul)) width_err++;
    prev_jog = jogada;
    prev_mul = multipla;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(string name, int nj, int nm, logic [3:0] re);
    exp_t e;
    e.name    = name;
    e.n_jog   = nj;
    e.n_mul   = nm;
    e.reg_exp = re;
    e.jog0    = jog_total;
    e.mul0    = mul_total;
    sb.push_back(e);
  endtask

  // Releases the switches, lets the FSM settle and scores the oldest entry.
  task automatic release_and_check();
    exp_t e;
    chaves = 4'b0000;
    repeat (8) tick();
    e = sb.pop_front();
    check({e.name, " jogada count"}, jog_total - e.jog0, e.n_jog);
    check({e.name, " multipla count"}, mul_total - e.mul0, e.n_mul);
    check({e.name, " chaves_reg"}, int'(chaves_reg), int'(e.reg_exp));
    check({e.name, " db_estado idle"}, int'(db_estado), 0);
  endtask

  initial begin
    int exp_db[8];

    vecs[0] = '{1'b1, 4'b0100,  2, 0, 0, 4'b0010};
    vecs[1] = '{1'b1, 4'b0101, 12, 0, 1, 4'b0010};
    vecs[2] = '{1'b1, 4'b1000, 50, 1, 0, 4'b1000};
    vecs[3] = '{1'b1, 4'b0001, 12, 1, 0, 4'b0001};
    vecs[4] = '{1'b0, 4'b0100, 12, 0, 0, 4'b0001};
    vecs[5] = '{1'b1, 4'b1111, 10, 0, 1, 4'b0001};
    vecs[6] = '{1'b1, 4'b0100,  4, 0, 0, 4'b0001};
    vecs[7] = '{1'b1, 4'b0100,  5, 1, 0, 4'b0100};
    vecs[8] = '{1'b1, 4'b0011,  4, 0, 0, 4'b0100};
    vecs[9] = '{1'b1, 4'b0011,  5, 0, 1, 4'b0100};

    exp_db = '{0, 0, 1, 1, 1, 1, 2, 3};

    // Reset state
    reset    = 1'b1;
    habilita = 1'b0;
    chaves   = 4'b0000;
    repeat (3) tick();
    check("reset db_estado", int'(db_estado), 0);
    check("reset jogada", int'(jogada), 0);
    check("reset multipla", int'(multipla), 0);
    check("reset chaves_reg", int'(chaves_reg), 0);

    // Cycle-exact latency: value present before edge 1, pulse after edge 7
    reset    = 1'b0;
    habilita = 1'b1;
    chaves   = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("latency edge %0d db_estado", i + 1), int'(db_estado), exp_db[i]);
      check($sformatf("latency edge %0d jogada", i + 1), int'(jogada), (exp_db[i] == 2) ? 1 : 0);
    end
    check("latency chaves_reg", int'(chaves_reg), 4'b0010);
    chaves = 4'b0000;
    tick();
    tick();
    check("release edge 2 db_estado", int'(db_estado), 3);
    tick();
    check("release edge 3 db_estado", int'(db_estado), 0);

    // Table-driven scenarios
    for (int v = 0; v < 10; v++) begin
      habilita = vecs[v].hab;
      push($sformatf("vec%0d", v), vecs[v].n_jog, vecs[v].n_mul, vecs[v].reg_exp);
      chaves = vecs[v].ch;
      repeat (vecs[v].hold) tick();
      release_and_check();
    end
    habilita = 1'b1;

    // Value changes mid-filter: refilter and emit the new value only
    push("change in filtra", 1, 0, 4'b0010);
    chaves = 4'b0001;
    repeat (4) tick();
    chaves = 4'b0010;
    repeat (12) tick();
    release_and_check();

    // Reset during FILTRA
    chaves = 4'b0100;
    for (int i = 0; i < 20 && db_estado != 4'h1; i++) tick();
    check("reach filtra", int'(db_estado), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset in filtra db_estado", int'(db_estado), 0);
    check("reset in filtra chaves_reg", int'(chaves_reg), 0);
    check("reset in filtra jogada", int'(jogada), 0);
    check("reset in filtra multipla", int'(multipla), 0);
    push("after reset", 1, 0, 4'b0100);
    repeat (12) tick();
    release_and_check();

    // Reset during EMITE
    chaves = 4'b1000;
    for (int i = 0; i < 30 && jogada != 1'b1; i++) tick();
    check("reach emite", int'(jogada), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset in emite db_estado", int'(db_estado), 0);
    check("reset in emite chaves_reg", int'(chaves_reg), 0);
    check("reset in emite jogada", int'(jogada), 0);
    chaves = 4'b0000;
    repeat (8) tick();

    check("pulse width violations", width_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/detector_jogada.md
DETECTOR_JOGADA -- requirements
Module: detector_jogada

Interface
REQ-001 Parameter: DEBOUNCE, default 4, number of consecutive clock cycles a nonzero switch value must stay stable before it is accepted; legal range 1..255.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising edge of clock.
REQ-004 habilita  input  1  enables detection of new plays (driven by control unit).
REQ-005 chaves  input  4  raw, asynchronous, bouncing switch inputs.
REQ-006 jogada  output  1  one-cycle pulse: valid one-hot play accepted.
REQ-007 multipla  output  1  one-cycle pulse: stable value with more than one bit set rejected.
REQ-008 chaves_reg  output  4  last accepted one-hot play value; feeds the downstream switch register/comparator.
REQ-009 db_estado  output  4  debug encoding of current FSM state.

Function
REQ-010 chaves SHALL pass through a 2-flop synchronizer (s1, s2); all decisions SHALL use s2 only.
REQ-011 FSM states/encodings SHALL be OCIOSO=0x0, FILTRA=0x1, EMITE=0x2, ESPERA=0x3, INVALIDA=0xE; db_estado SHALL equal the current encoding; any unused encoding SHALL go to OCIOSO next edge.
REQ-012 OCIOSO: habilita=1 and s2!=0 -> FILTRA, capture cap<=s2, cnt<=0; otherwise stay.
REQ-013 FILTRA: s2!=cap or habilita=0 -> OCIOSO (bounce/abort, cnt<=0); else if cnt==DEBOUNCE-1 -> EMITE when cap is one-hot, INVALIDA otherwise; else cnt<=cnt+1.
REQ-014 Entering EMITE SHALL load chaves_reg<=cap on the same edge; chaves_reg SHALL hold at all other times.
REQ-015 EMITE -> ESPERA unconditionally; INVALIDA -> ESPERA unconditionally.
REQ-016 ESPERA: stay while s2!=0 (regardless of habilita); s2==0 -> OCIOSO.
REQ-017 Outputs SHALL be Moore: jogada=1 only in EMITE, multipla=1 only in INVALIDA; each pulse exactly one cycle.
REQ-018 Latency: value stable from before edge 1 -> jogada high in the cycle following edge DEBOUNCE+3 (edge 7 for DEBOUNCE=4).
REQ-019 A held switch SHALL produce exactly one jogada; a new play requires s2==0 observed in ESPERA first.
REQ-020 cnt SHALL be 8 bits and never wrap in FILTRA (exits at DEBOUNCE-1).

Reset
REQ-021 reset=1 at a rising edge SHALL force state OCIOSO, s1=s2=0, cap=0, cnt=0, chaves_reg=0000, jogada=0, multipla=0, db_estado=0x0, overriding all other inputs, including mid-FILTRA/EMITE.
REQ-022 No pulse SHALL be emitted in the cycle following a reset edge.

Verification (DEBOUNCE=4)
REQ-023 Reset, habilita=1, chaves=0010 steady -> jogada=1 for one cycle after edge 7, chaves_reg=0010, db_estado 0->1->2->3; chaves=0000 -> db_estado=0 three edges later.
REQ-024 chaves=0100 for 2 cycles then 0000 -> no jogada, db_estado returns 0x0, chaves_reg unchanged.
REQ-025 chaves=0101 steady -> multipla=1 one cycle (db_estado=0xE), no jogada, chaves_reg unchanged, then 0x3 until release.
REQ-026 chaves=1000 held 50 cycles -> exactly one jogada; release then 0001 again -> second jogada, chaves_reg=0001.
REQ-027 chaves 0001 changes to 0010 during FILTRA -> OCIOSO, refilter, single jogada with chaves_reg=0010.
REQ-028 habilita=0 with chaves=0100 -> no jogada/multipla, db_estado=0x0; reset=1 during FILTRA -> db_estado=0x0 next edge, no pulse.
